// File: rtl/match_controller.sv
// Match sequencer: serve, play, point and game-over control for the ball.
// Optional PAUSE_EN macro adds pauseBtn and a frozen PAUSED state.
module match_controller #(
  parameter int sWidth      = 800,
  parameter int missMargin  = 2,
  parameter int serveFrames = 60,
  parameter int winScore    = 7
) (
  input  logic        PixelClock,
  input  logic        Reset,
  input  logic        frameTick,
  input  logic        startBtn,
`ifdef PAUSE_EN
  input  logic        pauseBtn,
`endif
  input  logic [10:0] ballLeft,
  input  logic [10:0] ballRight,
  output logic        ballReset,
  output logic        ballRun,
  output logic [3:0]  scoreLeft,
  output logic [3:0]  scoreRight,
  output logic        pointPulse,
  output logic [1:0]  winner,
  output logic [2:0]  matchState
);

  localparam int CntW =
    (serveFrames > 1) ? $clog2(serveFrames) : 1;

  localparam logic [CntW-1:0] LastCnt =
    CntW'(serveFrames - 1);

  localparam logic [10:0] LeftEdge =
    11'(missMargin);

  localparam logic [10:0] RightEdge =
    11'(sWidth - missMargin);

  localparam logic [3:0] WinVal =
    4'(winScore);

  typedef enum logic [2:0] {
    Idle     = 3'd0,
    Serve    = 3'd1,
    Play     = 3'd2,
    Point    = 3'd3,
`ifdef PAUSE_EN
    GameOver = 3'd4,
    Paused   = 3'd5
`else
    GameOver = 3'd4
`endif
  } stateT;

  stateT           state;
  logic [CntW-1:0] serveCnt;
  logic            startQ;
  logic            scorerRight;
  logic            startRise;
  logic            leftMiss;
  logic            rightMiss;
  logic [1:0]      missHot;

`ifdef PAUSE_EN
  logic pauseQ;
  logic pauseRise;

  assign pauseRise = pauseBtn & ~pauseQ;
`endif

  assign startRise = startBtn & ~startQ;
  assign leftMiss  = ballLeft <= LeftEdge;
  assign rightMiss = ballRight >= RightEdge;

  // Left-edge miss wins a simultaneous double miss.
  assign missHot = {leftMiss,
                    rightMiss & ~leftMiss};

  assign matchState = state;

  function automatic logic [3:0] satInc(
    input logic [3:0] s
  );
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  always_ff @(posedge PixelClock) begin
    if (Reset) begin
      state       <= Idle;
      serveCnt    <= '0;
      startQ      <= 1'b0;
      scorerRight <= 1'b0;
      ballReset   <= 1'b1;
      ballRun     <= 1'b0;
      scoreLeft   <= 4'd0;
      scoreRight  <= 4'd0;
      pointPulse  <= 1'b0;
      winner      <= 2'd0;
`ifdef PAUSE_EN
      pauseQ      <= 1'b0;
`endif
    end else begin
      startQ     <= startBtn;
      pointPulse <= 1'b0;
`ifdef PAUSE_EN
      pauseQ     <= pauseBtn;
`endif

      // Ball control follows the state one cycle late.
      case (state)
        Play: begin
          ballReset <= 1'b0;
          ballRun   <= 1'b1;
        end
`ifdef PAUSE_EN
        Paused: begin
          ballReset <= 1'b0;
          ballRun   <= 1'b0;
        end
`endif
        default: begin
          ballReset <= 1'b1;
          ballRun   <= 1'b0;
        end
      endcase

      case (state)
        Idle: begin
          if (startRise) begin
            state      <= Serve;
            serveCnt   <= '0;
            scoreLeft  <= 4'd0;
            scoreRight <= 4'd0;
            winner     <= 2'd0;
          end
        end

        Serve: begin
          if (frameTick) begin
            if (serveCnt == LastCnt) begin
              state    <= Play;
              serveCnt <= '0;
            end else begin
              serveCnt <= serveCnt + 1'b1;
            end
          end
        end

        Play: begin
          unique case (1'b1)
            missHot[1]: begin
              scoreRight  <= satInc(scoreRight);
              scorerRight <= 1'b1;
              pointPulse  <= 1'b1;
              state       <= Point;
            end
            missHot[0]: begin
              scoreLeft   <= satInc(scoreLeft);
              scorerRight <= 1'b0;
              pointPulse  <= 1'b1;
              state       <= Point;
            end
            default: begin
`ifdef PAUSE_EN
              if (pauseRise) begin
                state <= Paused;
              end
`endif
            end
          endcase
        end

        Point: begin
          if (scorerRight ?
              (scoreRight == WinVal) :
              (scoreLeft == WinVal)) begin
            state  <= GameOver;
            winner <= scorerRight ? 2'd2 : 2'd1;
          end else begin
            state    <= Serve;
            serveCnt <= '0;
          end
        end

        GameOver: begin
          if (startRise) begin
            state      <= Serve;
            serveCnt   <= '0;
            scoreLeft  <= 4'd0;
            scoreRight <= 4'd0;
            winner     <= 2'd0;
          end
        end

`ifdef PAUSE_EN
        Paused: begin
          if (pauseRise) begin
            state <= Play;
          end
        end
`endif

        default: begin
          state <= Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Randomised match bench for match_controller.
// Scores and winner predicted from rally outcomes.
module tb_match_controller;

  logic        PixelClock = 1'b0;
  logic        Reset;
  logic        frameTick;
  logic        startBtn;
`ifdef PAUSE_EN
  logic        pauseBtn;
`endif
  logic [10:0] ballLeft;
  logic [10:0] ballRight;
  logic        ballReset;
  logic        ballRun;
  logic [3:0]  scoreLeft;
  logic [3:0]  scoreRight;
  logic        pointPulse;
  logic [1:0]  winner;
  logic [2:0]  matchState;

  int checks   = 0;
  int failures = 0;
  int modelL   = 0;
  int modelR   = 0;
  int modelWin = 0;

  match_controller dut (
    .PixelClock (PixelClock),
    .Reset      (Reset),
    .frameTick  (frameTick),
    .startBtn   (startBtn),
`ifdef PAUSE_EN
    .pauseBtn   (pauseBtn),
`endif
    .ballLeft   (ballLeft),
    .ballRight  (ballRight),
    .ballReset  (ballReset),
    .ballRun    (ballRun),
    .scoreLeft  (scoreLeft),
    .scoreRight (scoreRight),
    .pointPulse (pointPulse),
    .winner     (winner),
    .matchState (matchState)
  );

  always #5 PixelClock = ~PixelClock;

  task automatic check(string tag, int obs, int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PixelClock);
    #1;
  endtask

  task automatic neutral();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) begin
      ballLeft  = 11'd3;
      ballRight = 11'd19;
    end else if (r == 1) begin
      ballLeft  = 11'd781;
      ballRight = 11'd797;
    end else begin
      ballLeft  = 11'($urandom_range(3, 780));
      ballRight = ballLeft + 11'd16;
    end
  endtask

  task automatic press();
    startBtn = 1'b1;
    step();
    check("startState", matchState, 1);
    check("startScoreL", scoreLeft, 0);
    check("startScoreR", scoreRight, 0);
    check("startWinner", winner, 0);
    startBtn = 1'b0;
    step();
    modelL   = 0;
    modelR   = 0;
    modelWin = 0;
  endtask

  task automatic doServe();
    int gap;
    check("serveEntry", matchState, 1);
    for (int i = 0; i < 60; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) step();
      if (i == 30) begin
        startBtn = 1'b1;
        step();
        startBtn = 1'b0;
      end
      frameTick = 1'b1;
      step();
      frameTick = 1'b0;
      if (i == 58) check("serveHold", matchState, 1);
    end
    check("serveDone", matchState, 2);
    check("runLag", ballRun, 0);
    step();
    check("runOn", ballRun, 1);
    check("resetOff", ballReset, 0);
  endtask

`ifdef PAUSE_EN
  task automatic doPause();
    pauseBtn = 1'b1;
    step();
    pauseBtn = 1'b0;
    check("pauseEnter", matchState, 5);
    ballLeft  = 11'd0;
    ballRight = 11'd16;
    step();
    check("pauseRun", ballRun, 0);
    check("pauseReset", ballReset, 0);
    repeat (3) step();
    check("pauseNoPulse", pointPulse, 0);
    check("pauseScoreR", scoreRight, modelR);
    check("pauseHold", matchState, 5);
    pauseBtn = 1'b1;
    step();
    pauseBtn = 1'b0;
    neutral();
    check("pauseExit", matchState, 2);
    step();
    check("resumeRun", ballRun, 1);
  endtask
`endif

  task automatic doRally(output bit over);
    int n;
    int side;
    n = $urandom_range(1, 15);
    for (int i = 0; i < n; i++) begin
      neutral();
      step();
    end
    check("noPoint", pointPulse, 0);
    check("stillPlay", matchState, 2);
`ifdef PAUSE_EN
    if ($urandom_range(0, 2) == 0) doPause();
`endif
    side = $urandom_range(0, 2);
    if (side == 0) begin
      ballLeft  = 11'($urandom_range(0, 2));
      ballRight = ballLeft + 11'd16;
    end else if (side == 1) begin
      ballRight = 11'($urandom_range(798, 820));
      ballLeft  = ballRight - 11'd16;
    end else begin
      ballLeft  = 11'($urandom_range(0, 2));
      ballRight = 11'($urandom_range(798, 900));
    end
    if (side == 1) modelL = (modelL < 15) ? modelL + 1 : 15;
    else           modelR = (modelR < 15) ? modelR + 1 : 15;
    step();
    neutral();
    check("pulseOn", pointPulse, 1);
    check("scoreL", scoreLeft, modelL);
    check("scoreR", scoreRight, modelR);
    check("pointState", matchState, 3);
    check("resetLag", ballReset, 0);
    over = (side == 1) ? (modelL == 7) : (modelR == 7);
    if (over) modelWin = (side == 1) ? 1 : 2;
    step();
    check("pulseOff", pointPulse, 0);
    check("resetOn", ballReset, 1);
    check("afterPoint", matchState, over ? 4 : 1);
    check("winner", winner, modelWin);
  endtask

  task automatic playMatch();
    bit over;
    over = 1'b0;
    for (int k = 0; k < 20 && !over; k++) begin
      doServe();
      doRally(over);
    end
    check("matchOver", int'(over), 1);
    repeat (5) begin
      frameTick = 1'b1;
      ballLeft  = 11'd0;
      step();
    end
    frameTick = 1'b0;
    neutral();
    check("overHold", matchState, 4);
    check("overScoreL", scoreLeft, modelL);
    check("overScoreR", scoreRight, modelR);
    check("overWinner", winner, modelWin);
    check("overRun", ballRun, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout observed=0 expected=1");
    $fatal(1);
  end

  initial begin
    bit over;
    Reset     = 1'b1;
    frameTick = 1'b0;
    startBtn  = 1'b0;
`ifdef PAUSE_EN
    pauseBtn  = 1'b0;
`endif
    neutral();
    repeat (3) step();
    check("rstState", matchState, 0);
    check("rstBallReset", ballReset, 1);
    check("rstBallRun", ballRun, 0);
    check("rstScoreL", scoreLeft, 0);
    check("rstScoreR", scoreRight, 0);
    check("rstPulse", pointPulse, 0);
    check("rstWinner", winner, 0);
    Reset = 1'b0;
    repeat (4) begin
      frameTick = 1'b1;
      step();
    end
    frameTick = 1'b0;
    check("idleHold", matchState, 0);

    press();
    playMatch();
    press();

    for (int k = 0; k < 3; k++) begin
      doServe();
      doRally(over);
    end
    doServe();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midRstState", matchState, 0);
    check("midRstScoreL", scoreLeft, 0);
    check("midRstScoreR", scoreRight, 0);
    check("midRstBall", ballReset, 1);
    check("midRstRun", ballRun, 0);
    step();

    press();
    playMatch();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
